// File: rtl/tl_lamp_monitor.sv
// Receiving-end checker for the R/Y/G lamp lines: filters, decodes, times and order-checks phases.
// Define MON_CYCLE_CNT_EN to build the completed-cycle counter; otherwise cycle_count is tied to 0.
module tl_lamp_monitor #(
  parameter int TICK_CYC     = 50_000_000,
  parameter int GLITCH_CYC   = 4,
  parameter int RED_TICKS    = 20,
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 20,
  parameter int TOL_TICKS    = 1,
  parameter int DARK_TICKS   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        red,
  input  logic        yellow,
  input  logic        green,
  input  logic        err_clr,
  output logic [1:0]  phase,
  output logic [6:0]  dwell,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [15:0] cycle_count
);
  localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int GW = $clog2(GLITCH_CYC + 1);
  localparam logic [1:0] PH_R = 2'b00, PH_G = 2'b01, PH_Y = 2'b10, PH_N = 2'b11;

  typedef enum logic [1:0] {SYNC, TRACK, FLT} st_t;
  st_t st, st_nxt;

  logic [2:0]    s1, s2, cand, acc;
  logic [GW-1:0] gcnt;
  logic          acc_vld, acc_take, acc_evt;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic [1:0]    cur, new_ph;
  logic          chk, new_lit, new_conf, lit_now, in_dark, ord_ok;
  logic          flt, run_en, enter_lit;
  logic [2:0]    flt_code;
  logic [6:0]    dwell_inc;
  int            lo, hi;

  function automatic logic [1:0] dec(input logic [2:0] p);
    case (p)
      3'b100:  return PH_R;
      3'b001:  return PH_G;
      3'b010:  return PH_Y;
      default: return PH_N;
    endcase
  endfunction

  function automatic logic [1:0] succ(input logic [1:0] ph);
    case (ph)
      PH_R:    return PH_G;
      PH_G:    return PH_Y;
      default: return PH_R;
    endcase
  endfunction

  function automatic int exp_of(input logic [1:0] ph);
    case (ph)
      PH_R:    return RED_TICKS;
      PH_G:    return GREEN_TICKS;
      default: return YELLOW_TICKS;
    endcase
  endfunction

  // Pattern {red,yellow,green}: 2-flop sync, then accept after GLITCH_CYC identical samples.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1      <= '0;
      s2      <= '0;
      cand    <= '0;
      gcnt    <= '0;
      acc     <= '0;
      acc_vld <= 1'b0;
    end else begin
      s1   <= {red, yellow, green};
      s2   <= s1;
      cand <= s2;
      if (s2 != cand)                   gcnt <= GW'(1);
      else if (gcnt != GW'(GLITCH_CYC)) gcnt <= gcnt + 1'b1;
      if (acc_take) begin
        acc     <= s2;
        acc_vld <= 1'b1;
      end
    end
  end

  assign acc_take  = (s2 == cand) && (gcnt == GW'(GLITCH_CYC - 1));
  assign acc_evt   = acc_take && (!acc_vld || (s2 != acc));
  assign tick      = (tcnt == TW'(TICK_CYC - 1));
  assign new_ph    = dec(s2);
  assign new_lit   = (new_ph != PH_N);
  assign new_conf  = ($countones(s2) > 1);
  assign lit_now   = acc_vld && (dec(acc) != PH_N);
  assign in_dark   = acc_vld && (acc == 3'b000);
  assign dwell_inc = (tick && (dwell != 7'd127)) ? dwell + 7'd1 : dwell;

  // Fault detection, highest priority first. A dark gap is a pause: order is
  // checked against the last lit phase, and returning to that same phase is legal.
  always_comb begin
    flt      = 1'b0;
    flt_code = 3'd0;
    lo       = exp_of(cur) - TOL_TICKS;
    hi       = exp_of(cur) + TOL_TICKS;
    ord_ok   = lit_now ? (new_ph == succ(cur)) : ((new_ph == succ(cur)) || (new_ph == cur));
    if ((st != FLT) && !err_clr) begin
      if (acc_evt && new_conf) begin
        flt = 1'b1; flt_code = 3'd1;
      end else if (in_dark && !acc_evt && (int'(dwell_inc) >= DARK_TICKS)) begin
        flt = 1'b1; flt_code = 3'd2;
      end else if (st == TRACK) begin
        if (acc_evt && new_lit && !ord_ok) begin
          flt = 1'b1; flt_code = 3'd3;
        end else if (acc_evt && new_lit && lit_now && chk && (int'(dwell) < lo)) begin
          flt = 1'b1; flt_code = 3'd4;
        end else if (acc_evt && new_lit && lit_now && chk && (int'(dwell) > hi)) begin
          flt = 1'b1; flt_code = 3'd5;
        end else if (!acc_evt && lit_now && chk && (int'(dwell_inc) > hi)) begin
          flt = 1'b1; flt_code = 3'd5;
        end
      end
    end
  end

  always_comb begin
    st_nxt = st;
    if (err_clr)                               st_nxt = SYNC;
    else if (flt)                              st_nxt = FLT;
    else if ((st == SYNC) && acc_evt && new_lit) st_nxt = TRACK;
  end

  always_comb begin
    run_en    = (st != FLT) && !err_clr;
    enter_lit = run_en && !flt && acc_evt && new_lit;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st         <= SYNC;
      phase      <= PH_N;
      dwell      <= '0;
      tcnt       <= '0;
      fault      <= 1'b0;
      fault_code <= 3'd0;
      cur        <= PH_R;
      chk        <= 1'b0;
    end else begin
      st <= st_nxt;
      if (acc_evt) phase <= new_ph;
      if (err_clr) begin
        fault      <= 1'b0;
        fault_code <= 3'd0;
        dwell      <= '0;
        tcnt       <= '0;
        chk        <= 1'b0;
      end else if (run_en) begin
        tcnt  <= (acc_evt || tick) ? '0 : tcnt + 1'b1;
        dwell <= acc_evt ? '0 : dwell_inc;
        if (flt) begin
          fault      <= 1'b1;
          fault_code <= flt_code;
        end
        if (enter_lit) begin
          cur <= new_ph;
          chk <= (st == TRACK) && (lit_now || (new_ph != cur));
        end
      end
    end
  end

`ifdef MON_CYCLE_CNT_EN
  logic prev_chk;
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_chk    <= 1'b0;
      cycle_count <= '0;
    end else if (err_clr) begin
      prev_chk <= 1'b0;
    end else if (enter_lit) begin
      prev_chk <= (st == TRACK) && lit_now && chk;
      if ((st == TRACK) && lit_now && (cur == PH_Y) && (new_ph == PH_R) && chk && prev_chk &&
          (cycle_count != 16'hFFFF))
        cycle_count <= cycle_count + 16'd1;
    end
  end
`else
  assign cycle_count = 16'd0;
`endif

endmodule

// File: tb/tb_tl_lamp_monitor.sv
// Directed bench for tl_lamp_monitor: phase changes checked through an expected-phase queue,
// fault/dwell/counter values checked with immediate assertions at fixed points.
module tb_tl_lamp_monitor;
  logic        clk = 1'b0, reset = 1'b0;
  logic        red = 1'b0, yellow = 1'b0, green = 1'b0, err_clr = 1'b0;
  logic [1:0]  phase;
  logic [6:0]  dwell;
  logic        fault;
  logic [2:0]  fault_code;
  logic [15:0] cycle_count;

  int         n_cmp = 0, n_err = 0;
  logic [1:0] exp_q[$];
  logic [1:0] last_ph = 2'b11;
  logic [1:0] e_ph;

  localparam logic [2:0] L_R = 3'b100, L_Y = 3'b010, L_G = 3'b001, L_OFF = 3'b000, L_RG = 3'b101;
`ifdef MON_CYCLE_CNT_EN
  localparam logic [15:0] CC1 = 16'd1;
`else
  localparam logic [15:0] CC1 = 16'd0;
`endif

  tl_lamp_monitor #(
    .TICK_CYC(10), .GLITCH_CYC(4), .RED_TICKS(20), .GREEN_TICKS(20), .YELLOW_TICKS(20),
    .TOL_TICKS(1), .DARK_TICKS(2)
  ) dut (
    .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green), .err_clr(err_clr),
    .phase(phase), .dwell(dwell), .fault(fault), .fault_code(fault_code), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Every phase change seen while out of reset must match the next queued expectation.
  always @(negedge clk) begin
    if (reset && (phase !== last_ph)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL phase_unexpected: observed %0d expected none queued", phase);
      end else begin
        e_ph = exp_q.pop_front();
        assert (phase === e_ph) else begin
          n_err++;
          $error("FAIL phase_seq: observed %0d expected %0d", phase, e_ph);
        end
      end
    end
    last_ph = phase;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] e);
    exp_q.push_back(e);
  endtask

  task automatic run(input logic [2:0] p, input int n);
    {red, yellow, green} = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check_state);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    exp_q.delete();
    reset = 1'b0;
    err_clr = 1'b0;
    {red, yellow, green} = L_R;
    repeat (3) @(posedge clk);
    #1;
    if (check_state) begin
      chk("rst_phase", 16'(phase), 16'h3);
      chk("rst_dwell", 16'(dwell), 16'd0);
      chk("rst_fault", 16'(fault), 16'd0);
      chk("rst_code", 16'(fault_code), 16'd0);
      chk("rst_cycle_count", cycle_count, 16'd0);
    end
    push(2'b00);
    reset = 1'b1;
  endtask

  initial begin
    // 1: clean R->G->Y->R
    do_reset(1'b1);
    run(L_R, 200);
    push(2'b01); run(L_G, 200);
    push(2'b10); run(L_Y, 200);
    push(2'b00); run(L_R, 200);
    chk("t1_fault", 16'(fault), 16'd0);
    chk("t1_code", 16'(fault_code), 16'd0);
    chk("t1_phase", 16'(phase), 16'h0);
    chk("t1_dwell", 16'(dwell), 16'd19);
    chk("t1_cycle_count", cycle_count, CC1);

    // 2: short R+G glitch filtered, long one latches conflict with fixed latency
    do_reset(1'b0);
    run(L_R, 200);
    push(2'b01); run(L_G, 100);
    run(L_RG, 2);
    run(L_G, 50);
    chk("t2_glitch_fault", 16'(fault), 16'd0);
    chk("t2_glitch_phase", 16'(phase), 16'h1);
    push(2'b11);
    {red, yellow, green} = L_RG;
    repeat (5) @(posedge clk);
    #1;
    chk("t2_fault_early", 16'(fault), 16'd0);
    @(posedge clk);
    #1;
    chk("t2_fault", 16'(fault), 16'd1);
    chk("t2_code", 16'(fault_code), 16'd1);
    run(L_RG, 10);
    push(2'b01); run(L_G, 20);
    chk("t2_code_held", 16'(fault_code), 16'd1);

    // 3: short green, then long green caught in-phase
    do_reset(1'b0);
    run(L_R, 200);
    push(2'b01); run(L_G, 150);
    push(2'b10); run(L_Y, 20);
    chk("t3_short_fault", 16'(fault), 16'd1);
    chk("t3_short_code", 16'(fault_code), 16'd4);
    do_reset(1'b0);
    run(L_R, 200);
    push(2'b01); run(L_G, 225);
    chk("t3_long_pre_fault", 16'(fault), 16'd0);
    chk("t3_long_pre_dwell", 16'(dwell), 16'd21);
    run(L_G, 5);
    chk("t3_long_fault", 16'(fault), 16'd1);
    chk("t3_long_code", 16'(fault_code), 16'd5);
    chk("t3_long_dwell", 16'(dwell), 16'd22);
    push(2'b10); run(L_Y, 30);
    chk("t3_code_sticky", 16'(fault_code), 16'd5);
    chk("t3_dwell_frozen", 16'(dwell), 16'd22);

    // 4: order fault, clear, first phase after resync is untimed
    do_reset(1'b0);
    run(L_R, 100);
    push(2'b10); run(L_Y, 20);
    chk("t4_code", 16'(fault_code), 16'd3);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("t4_clr_fault", 16'(fault), 16'd0);
    chk("t4_clr_code", 16'(fault_code), 16'd0);
    chk("t4_clr_dwell", 16'(dwell), 16'd0);
    push(2'b00); run(L_R, 50);
    push(2'b01); run(L_G, 100);
    chk("t4_resync_fault", 16'(fault), 16'd0);

    // 5: long dark faults, short dark gap between phases does not
    do_reset(1'b0);
    run(L_R, 100);
    push(2'b11); run(L_OFF, 25);
    push(2'b01); run(L_G, 10);
    chk("t5_dark_fault", 16'(fault), 16'd1);
    chk("t5_dark_code", 16'(fault_code), 16'd2);
    do_reset(1'b0);
    run(L_R, 100);
    push(2'b11); run(L_OFF, 15);
    push(2'b01); run(L_G, 100);
    chk("t5_gap_fault", 16'(fault), 16'd0);
    chk("t5_gap_phase", 16'(phase), 16'h1);

    // 6: reset while faulted mid-yellow
    do_reset(1'b0);
    run(L_R, 50);
    push(2'b10); run(L_Y, 30);
    chk("t6_pre_fault", 16'(fault), 16'd1);
    chk("t6_queue", 16'(exp_q.size()), 16'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_phase", 16'(phase), 16'h3);
    chk("t6_dwell", 16'(dwell), 16'd0);
    chk("t6_fault", 16'(fault), 16'd0);
    chk("t6_code", 16'(fault_code), 16'd0);
    chk("t6_cycle_count", cycle_count, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
